// File: rtl/paddle_pos_ctrl.sv
// paddle_pos_ctrl: rate-limited, accelerating, saturating paddle position integrator for two players
module paddle_pos_ctrl #(
  parameter int         TICK_BITS   = 14,
  parameter int         ACCEL_TICKS = 16,
  parameter logic [7:0] MIN_POS     = 8'h10,
  parameter logic [7:0] MAX_POS     = 8'hF0,
  parameter logic [7:0] CENTRE_POS  = 8'h80
) (
  input  logic       clk_28M,
  input  logic       pll_lckd,
  input  logic       ena_7,
  input  logic       centre,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [7:0] paddle1_vpos,
  output logic [7:0] paddle2_vpos,
  output logic       step_tick
);
  localparam int HW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(ACCEL_TICKS - 1);
  typedef enum logic [1:0] {IDLE, SLOW, FAST2, FAST4} spd_t;
  logic [TICK_BITS-1:0] pre_cnt;
  logic [4:0] sync1, sync2;
  logic centre_s;
  logic [1:0] up_s, dn_s;
  logic [1:0][7:0] vpos;
  always_ff @(posedge clk_28M or negedge pll_lckd)
    if (!pll_lckd) begin
      pre_cnt   <= '0;
      step_tick <= 1'b0;
      sync1     <= '0;
      sync2     <= '0;
    end else begin
      if (ena_7) pre_cnt <= pre_cnt + TICK_BITS'(1);
      step_tick <= ena_7 && (&pre_cnt);
      sync1     <= {centre, p2_down, p2_up, p1_down, p1_up};
      sync2     <= sync1;
    end
  assign centre_s = sync2[4];
  assign up_s     = {sync2[2], sync2[0]};
  assign dn_s     = {sync2[3], sync2[1]};
  for (genvar g = 0; g < 2; g++) begin : g_player
    spd_t state, state_nx;
    logic [HW-1:0] hold, hold_nx;
    logic last_up, last_nx;
    logic mv_up, mv_dn, same;
    logic [2:0] step;
    logic [8:0] sum, diff;
    logic [7:0] pos, pos_nx;
    assign mv_up = up_s[g] & ~dn_s[g];
    assign mv_dn = dn_s[g] & ~up_s[g];
    assign same  = (mv_up & last_up) | (mv_dn & ~last_up);
    always_ff @(posedge clk_28M or negedge pll_lckd)
      if (!pll_lckd) begin
        state   <= IDLE;
        hold    <= '0;
        last_up <= 1'b0;
        pos     <= CENTRE_POS;
      end else begin
        state   <= state_nx;
        hold    <= hold_nx;
        last_up <= last_nx;
        pos     <= pos_nx;
      end
    always_comb begin
      state_nx = state;
      hold_nx  = hold;
      last_nx  = last_up;
      if (centre_s) begin
        state_nx = IDLE;
        hold_nx  = '0;
      end else if (step_tick) begin
        if (!(mv_up | mv_dn)) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (state == IDLE || !same) begin
          state_nx = SLOW;
          hold_nx  = '0;
          last_nx  = mv_up;
        end else if (state != FAST4 && hold == HOLD_MAX) begin
          state_nx = spd_t'(state + 2'd1);
          hold_nx  = '0;
        end else
          hold_nx = (hold == HOLD_MAX) ? hold : hold + HW'(1);
      end
    end
    // step size follows the state being entered, so a promotion tick already moves faster
    always_comb begin
      step   = (state_nx == FAST4) ? 3'd4 : (state_nx == FAST2) ? 3'd2 :
               (state_nx == SLOW) ? 3'd1 : 3'd0;
      sum    = {1'b0, pos} + {6'd0, step};
      diff   = {1'b0, pos} - {6'd0, step};
      pos_nx = centre_s ? CENTRE_POS :
               !step_tick ? pos :
               mv_up ? ((sum > {1'b0, MAX_POS}) ? MAX_POS : sum[7:0]) :
               mv_dn ? ((diff[8] || diff[7:0] < MIN_POS) ? MIN_POS : diff[7:0]) : pos;
    end
    assign vpos[g] = pos;
  end
  assign paddle1_vpos = vpos[0];
  assign paddle2_vpos = vpos[1];
endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// tb_paddle_pos_ctrl: directed checks of paddle speed, saturation, centre and reset behaviour
module tb_paddle_pos_ctrl;
  logic clk_28M = 1'b0;
  logic pll_lckd = 1'b1;
  logic ena_7 = 1'b0;
  logic centre = 1'b0;
  logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [7:0] paddle1_vpos, paddle2_vpos;
  logic step_tick;
  int tests = 0;
  int fails = 0;

  paddle_pos_ctrl #(.TICK_BITS(2)) dut (
    .clk_28M(clk_28M), .pll_lckd(pll_lckd), .ena_7(ena_7), .centre(centre),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .paddle1_vpos(paddle1_vpos), .paddle2_vpos(paddle2_vpos), .step_tick(step_tick)
  );

  always #5 clk_28M = ~clk_28M;

  initial begin : ena_gen
    int k;
    k = 0;
    forever begin
      @(negedge clk_28M);
      k++;
      ena_7 = (k % 4 == 0);
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pos_is(input string tag, input logic [7:0] e1, input logic [7:0] e2);
    check({tag, "_p1"}, paddle1_vpos, e1);
    check({tag, "_p2"}, paddle2_vpos, e2);
  endtask

  // returns at the falling edge just after the edge that consumed a step_tick
  task automatic next_tick();
    int n;
    n = 0;
    while (step_tick !== 1'b1 && n < 64) begin
      @(negedge clk_28M);
      n++;
    end
    if (n >= 64) check("tick_timeout", 8'd0, 8'd1);
    @(negedge clk_28M);
  endtask

  task automatic ticks(input int n);
    repeat (n) next_tick();
  endtask

  initial begin
    #2 pll_lckd = 1'b0;
    repeat (5) @(negedge clk_28M);
    pos_is("reset", 8'h80, 8'h80);
    check("reset_tick", {7'd0, step_tick}, 8'd0);
    pll_lckd = 1'b1;
    ticks(3);
    pos_is("idle3", 8'h80, 8'h80);

    p1_up = 1'b1;
    ticks(1);
    pos_is("slow1", 8'h81, 8'h80);
    ticks(15);
    pos_is("slow16", 8'h90, 8'h80);
    ticks(16);
    pos_is("fast2", 8'hB0, 8'h80);
    ticks(1);
    pos_is("fast4a", 8'hB4, 8'h80);
    ticks(1);
    pos_is("fast4b", 8'hB8, 8'h80);
    p1_up = 1'b0;
    ticks(1);
    pos_is("release", 8'hB8, 8'h80);

    p2_down = 1'b1;
    ticks(32);
    pos_is("p2_down32", 8'hB8, 8'h50);
    ticks(16);
    pos_is("p2_floor", 8'hB8, 8'h10);
    ticks(12);
    pos_is("p2_floor_hold", 8'hB8, 8'h10);
    p2_down = 1'b0;

    centre = 1'b1;
    repeat (4) @(negedge clk_28M);
    centre = 1'b0;
    repeat (3) @(negedge clk_28M);
    pos_is("centre", 8'h80, 8'h80);

    p1_up = 1'b1; ticks(1);
    p1_up = 1'b0; ticks(1);
    pos_is("nudge1", 8'h81, 8'h80);
    p1_up = 1'b1; ticks(1);
    p1_up = 1'b0; ticks(1);
    pos_is("nudge2", 8'h82, 8'h80);
    p1_up = 1'b1;
    ticks(47);
    pos_is("at_ee", 8'hEE, 8'h80);
    ticks(1);
    pos_is("clamp", 8'hF0, 8'h80);
    ticks(3);
    pos_is("clamp_hold", 8'hF0, 8'h80);

    p1_up = 1'b0; p1_down = 1'b1;
    ticks(1);
    pos_is("reverse", 8'hEF, 8'h80);
    p1_up = 1'b1;
    ticks(2);
    pos_is("both_held", 8'hEF, 8'h80);
    p1_up = 1'b0;
    ticks(1);
    pos_is("resume_dn", 8'hEE, 8'h80);

    p1_up = 1'b1; p1_down = 1'b0; p2_down = 1'b1;
    ticks(1);
    pos_is("both_move1", 8'hEF, 8'h7F);
    next_tick();
    pos_is("both_move2", 8'hF0, 8'h7E);
    repeat (13) @(negedge clk_28M);
    centre = 1'b1;
    repeat (2) @(negedge clk_28M);
    check("coincide_tick", {7'd0, step_tick}, 8'd1);
    pos_is("pre_centre", 8'hF0, 8'h7E);
    centre = 1'b0;
    @(negedge clk_28M);
    pos_is("centre_tick", 8'h80, 8'h80);
    next_tick();
    pos_is("after_centre", 8'h81, 8'h7F);
    ticks(15);
    pos_is("again16", 8'h90, 8'h70);
    ticks(3);
    pos_is("mid_fast2", 8'h96, 8'h6A);
    @(negedge clk_28M);
    #2 pll_lckd = 1'b0;
    #1;
    pos_is("async_reset", 8'h80, 8'h80);
    check("async_reset_tick", {7'd0, step_tick}, 8'd0);
    @(negedge clk_28M);
    pll_lckd = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
